// File: rtl/borrow_chain_serial_sub_pkg.sv
// borrow_chain_serial_sub_pkg
//   Shared definitions for the borrow-chain family. It holds the FSM state
//   encodings and a ceil-log2 helper that sizes the bit counter.
//   There are no ports: this is a package imported by the RTL files.
package borrow_chain_serial_sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Returns the ceil-log2 of v, with a minimum of 1 so that a counter always has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) begin
      r = r + 32'sd1;
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/borrow_chain_1bit.sv
// borrow_chain_1bit
//   Combinational 1-bit full subtractor. It computes diff = a ^ b ^ bin and
//   bout = borrow out of (a - b - bin). It is the mirror of the 1-bit carry cell.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   diff out  difference bit
//   bout out  borrow out
module borrow_chain_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic axb_s;

  assign axb_s = a ^ b;
  assign diff  = axb_s ^ bin;
  // A borrow is generated when a=0 and b=1. An incoming borrow propagates when a==b.
  assign bout  = (~a & b) | (~axb_s & bin);

endmodule

// File: rtl/borrow_chain_serial_sub.sv
// borrow_chain_serial_sub
//   Bit-serial subtractor that processes one bit per clock, LSB first. It
//   produces {bout, diff} = a - b - bin. A single borrow_chain_1bit cell is
//   reused across WIDTH RUN cycles. The block uses valid/ready handshakes on
//   both sides, and a new operation never overlaps the previous one.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   in_valid  in   a/b/bin valid
//   in_ready  out  an operand set can be accepted (only in IDLE)
//   a         in   minuend, WIDTH bits
//   b         in   subtrahend, WIDTH bits
//   bin       in   borrow in
//   out_valid out  diff/bout valid (only in DONE)
//   out_ready in   consumer accepts the result
//   diff      out  (a - b - bin) mod 2^WIDTH, WIDTH bits
//   bout      out  borrow out, 1 when a < b + bin
module borrow_chain_serial_sub
  import borrow_chain_serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic             brw_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             cell_diff_s;
  logic             cell_bout_s;

  // The single subtractor cell always sees the current LSBs and the running borrow.
  borrow_chain_1bit u_cell (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (brw_r),
    .diff (cell_diff_s),
    .bout (cell_bout_s)
  );

  // This block holds the FSM, the counter, the operand and result shift registers, and the handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      brw_r       <= 1'b0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sr_r     <= a;
            b_sr_r     <= b;
            brw_r      <= bin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= S_RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_RUN: begin
          // Each new bit enters at the MSB. After WIDTH shifts, bit 0 holds the first bit computed.
          diff_r <= {cell_diff_s, diff_r[WIDTH-1:1]};
          a_sr_r <= a_sr_r >> 1;
          b_sr_r <= b_sr_r >> 1;
          brw_r  <= cell_bout_s;
          if (cnt_r == CNT_LAST) begin
            bout_r      <= cell_bout_s;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;

endmodule

// File: tb/tb_borrow_chain_serial_sub.sv
// tb_borrow_chain_serial_sub
//   Directed and random self-checking bench for borrow_chain_serial_sub with WIDTH=4.
module tb_borrow_chain_serial_sub;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       bout;

  int n_vec;
  int n_err;

  borrow_chain_serial_sub #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // This task runs one operation. It randomises a/b/bin during RUN, checks the latency and the result,
  // and optionally stalls out_ready for 'gap' cycles before it releases the result.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [3:0] ediff, input logic ebout, input int gap, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_diff"}, {28'd0, diff}, {28'd0, ediff});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
    for (int i = 0; i < gap; i++) begin
      tick();
      chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_stall_diff"}, {28'd0, diff}, {28'd0, ediff});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_hold_diff"}, {28'd0, diff}, {28'd0, ediff});
  endtask

  initial begin
    logic [4:0] ref_v;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rbin;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", {28'd0, diff}, 32'd0);
    chk("reset_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 0, "v5m3");
    run_op(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 0, "v3m5");
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 0, "v0m0b");
    run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 0, "vFmFb");
    run_op(4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 2, "vFm0");

    // In DONE, out_ready stays low while in_valid stays high for 10 cycles.
    a = 4'h8; b = 4'h1; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stall_entry_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1; a = 4'h2; b = 4'h1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_diff", {28'd0, diff}, 32'h7);
      chk("stall_bout", {31'd0, bout}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("unstall_out_valid", {31'd0, out_valid}, 32'd0);
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("next_accept", {31'd0, in_ready}, 32'd0);
    repeat (4) tick();
    chk("next_diff", {28'd0, diff}, 32'h1);
    chk("next_bout", {31'd0, bout}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // This step asserts rst in the middle of RUN, when cnt is 2.
    a = 4'hA; b = 4'h3; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_diff", {28'd0, diff}, 32'd0);
    chk("arst_bout", {31'd0, bout}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    run_op(4'h9, 4'h2, 1'b0, 4'h7, 1'b0, 0, "post_rst");

    // Random operations with random input and output gaps, checked against a 5-bit reference subtraction.
    for (int k = 0; k < 1000; k++) begin
      ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb} - {4'd0, rbin};
      repeat ($urandom_range(0, 2)) tick();
      run_op(ra, rb, rbin, ref_v[3:0], ref_v[4], $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
